// File: rtl/bus_dma_host.sv
// bus_dma_host: word-copy DMA engine that sits on a host port of the shared bus.
// Software programs SRC/DST/LEN through a small device-side register window and
// starts a copy. The engine then alternates read and write requests on the host
// port, one word at a time, and pulses done_o when the last word has been written.
//
// Ports:
//   clk_i, rst_i               clock, asynchronous active-low reset
//   cfg_req_i/cfg_we_i         register access strobe / write enable
//   cfg_addr_i                 register address, bits [3:2] select the register
//   cfg_wdata_i/cfg_rdata_o    register write data / read data (one cycle latency)
//   host_req_o/host_gnt_i      bus request / grant
//   host_addr_o/host_we_o      bus address / write enable
//   host_wdata_o/host_rdata_i  bus write data / read data (valid cycle after grant)
//   busy_o                     copy in progress (start+1 through the DONE cycle)
//   done_o                     one-cycle completion pulse
//
// Register map (cfg_addr_i[3:2]):
//   0 SRC   word-aligned source address
//   1 DST   word-aligned destination address
//   2 LEN   word count
//   3 CTRL  write: bit0 start, bit1 clear done; read: {busy, done}
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a start
// RD_REQ  | read request at cur_src held until granted
// RD_WAIT | read data arrives, latched into the write-data buffer
// WR_REQ  | write request at cur_dst held until granted
// DONE    | completion pulse, sticky done flag set, busy released

module bus_dma_host #(
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32,
    parameter int LenWidth     = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cfg_req_i,
    input  logic                    cfg_we_i,
    input  logic [AddressWidth-1:0] cfg_addr_i,
    input  logic [DataWidth-1:0]    cfg_wdata_i,
    output logic [DataWidth-1:0]    cfg_rdata_o,
    output logic                    host_req_o,
    input  logic                    host_gnt_i,
    output logic [AddressWidth-1:0] host_addr_o,
    output logic                    host_we_o,
    output logic [DataWidth-1:0]    host_wdata_o,
    input  logic [DataWidth-1:0]    host_rdata_i,
    output logic                    busy_o,
    output logic                    done_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                  state;
    logic [AddressWidth-1:0] src_reg;
    logic [AddressWidth-1:0] dst_reg;
    logic [LenWidth-1:0]     len_reg;
    logic [AddressWidth-1:0] cur_src;
    logic [AddressWidth-1:0] cur_dst;
    logic [LenWidth-1:0]     count;
    logic                    done_flag;

    logic [1:0] reg_sel;
    logic       cfg_wr;
    logic       cfg_rd;
    logic       start;
    logic       clr_done;

    assign reg_sel  = cfg_addr_i[3:2];
    assign cfg_wr   = cfg_req_i & cfg_we_i;
    assign cfg_rd   = cfg_req_i & ~cfg_we_i;
    assign start    = cfg_wr && (reg_sel == 2'd3) && cfg_wdata_i[0];
    assign clr_done = cfg_wr && (reg_sel == 2'd3) && cfg_wdata_i[1];

    logic unused;
    assign unused = ^{cfg_addr_i[AddressWidth-1:4], cfg_addr_i[1:0]};

    // Register window: programmed values are frozen while a copy runs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            src_reg     <= '0;
            dst_reg     <= '0;
            len_reg     <= '0;
            cfg_rdata_o <= '0;
        end else begin
            if (cfg_wr && !busy_o) begin
                case (reg_sel)
                    2'd0:    src_reg <= {cfg_wdata_i[AddressWidth-1:2], 2'b00};
                    2'd1:    dst_reg <= {cfg_wdata_i[AddressWidth-1:2], 2'b00};
                    2'd2:    len_reg <= cfg_wdata_i[LenWidth-1:0];
                    default: ;
                endcase
            end
            if (cfg_rd) begin
                case (reg_sel)
                    2'd0:    cfg_rdata_o <= DataWidth'(src_reg);
                    2'd1:    cfg_rdata_o <= DataWidth'(dst_reg);
                    2'd2:    cfg_rdata_o <= DataWidth'(len_reg);
                    default: cfg_rdata_o <= DataWidth'({busy_o, done_flag});
                endcase
            end
        end
    end

    // Copy engine. Bus outputs are registered and loaded on the transition into
    // each request state so they are stable for the whole request.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            cur_src      <= '0;
            cur_dst      <= '0;
            count        <= '0;
            done_flag    <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            host_req_o   <= 1'b0;
            host_we_o    <= 1'b0;
            host_addr_o  <= '0;
            host_wdata_o <= '0;
        end else begin
            // Clear-done is overridden below by a start or by the DONE-cycle set.
            if (clr_done) begin
                done_flag <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        done_flag <= 1'b0;
                        busy_o    <= 1'b1;
                        if (len_reg != '0) begin
                            cur_src     <= src_reg;
                            cur_dst     <= dst_reg;
                            count       <= len_reg;
                            host_req_o  <= 1'b1;
                            host_we_o   <= 1'b0;
                            host_addr_o <= src_reg;
                            state       <= RD_REQ;
                        end else begin
                            done_o <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                RD_REQ: begin
                    if (host_gnt_i) begin
                        host_req_o <= 1'b0;
                        state      <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    // host_wdata_o doubles as the word buffer.
                    host_wdata_o <= host_rdata_i;
                    host_req_o   <= 1'b1;
                    host_we_o    <= 1'b1;
                    host_addr_o  <= cur_dst;
                    state        <= WR_REQ;
                end
                WR_REQ: begin
                    if (host_gnt_i) begin
                        cur_src   <= cur_src + AddressWidth'(4);
                        cur_dst   <= cur_dst + AddressWidth'(4);
                        count     <= count - LenWidth'(1);
                        host_we_o <= 1'b0;
                        if (count == LenWidth'(1)) begin
                            host_req_o <= 1'b0;
                            done_o     <= 1'b1;
                            state      <= DONE;
                        end else begin
                            host_req_o  <= 1'b1;
                            host_addr_o <= cur_src + AddressWidth'(4);
                            state       <= RD_REQ;
                        end
                    end
                end
                DONE: begin
                    done_o    <= 1'b0;
                    busy_o    <= 1'b0;
                    done_flag <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_dma_host.sv
// Directed bench for bus_dma_host. A bus responder on the falling edge grants
// requests (optionally after a stall), supplies read data and logs every
// granted transaction; the main sequence checks the log, timing and registers.

module tb_bus_dma_host;

    logic        clk_i;
    logic        rst_i;
    logic        cfg_req_i;
    logic        cfg_we_i;
    logic [31:0] cfg_addr_i;
    logic [31:0] cfg_wdata_i;
    logic [31:0] cfg_rdata_o;
    logic        host_req_o;
    logic        host_gnt_i;
    logic [31:0] host_addr_o;
    logic        host_we_o;
    logic [31:0] host_wdata_o;
    logic [31:0] host_rdata_i;
    logic        busy_o;
    logic        done_o;

    bus_dma_host dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cfg_req_i    (cfg_req_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_wdata_i  (cfg_wdata_i),
        .cfg_rdata_o  (cfg_rdata_o),
        .host_req_o   (host_req_o),
        .host_gnt_i   (host_gnt_i),
        .host_addr_o  (host_addr_o),
        .host_we_o    (host_we_o),
        .host_wdata_o (host_wdata_o),
        .host_rdata_i (host_rdata_i),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int bad    = 0;

    // Responder state
    int          stall    = 0;
    int          wait_cnt = 0;
    int          stab_err = 0;
    logic [31:0] held_addr;
    logic        held_we;
    logic [31:0] held_wdata;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic        log_we[$];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h11;
            32'h0000_0104: return 32'h22;
            32'h0000_0108: return 32'h33;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    initial begin
        host_gnt_i   = 1'b0;
        host_rdata_i = 32'h0;
    end

    always @(negedge clk_i) begin
        if (host_req_o) begin
            if (wait_cnt == 0) begin
                held_addr  = host_addr_o;
                held_we    = host_we_o;
                held_wdata = host_wdata_o;
            end else if (host_addr_o !== held_addr || host_we_o !== held_we ||
                         host_wdata_o !== held_wdata) begin
                stab_err++;
            end
            if (wait_cnt >= stall) begin
                host_gnt_i = 1'b1;
                wait_cnt   = 0;
                log_addr.push_back(host_addr_o);
                log_we.push_back(host_we_o);
                if (host_we_o) begin
                    log_data.push_back(host_wdata_o);
                end else begin
                    host_rdata_i = mem_read(host_addr_o);
                    log_data.push_back(host_rdata_i);
                end
            end else begin
                host_gnt_i = 1'b0;
                wait_cnt++;
            end
        end else begin
            host_gnt_i = 1'b0;
            wait_cnt   = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cfg_write(input logic [31:0] a, input logic [31:0] d);
        cfg_req_i   = 1'b1;
        cfg_we_i    = 1'b1;
        cfg_addr_i  = a;
        cfg_wdata_i = d;
        @(negedge clk_i);
        cfg_req_i   = 1'b0;
        cfg_we_i    = 1'b0;
    endtask

    task automatic cfg_read(input logic [31:0] a, output logic [31:0] d);
        cfg_req_i  = 1'b1;
        cfg_we_i   = 1'b0;
        cfg_addr_i = a;
        @(negedge clk_i);
        cfg_req_i  = 1'b0;
        d          = cfg_rdata_o;
    endtask

    // cyc = 1 means done_o is already high at the current falling edge.
    task automatic wait_done(input int max, output int cyc);
        cyc = 1;
        while (done_o !== 1'b1 && cyc < max) begin
            @(negedge clk_i);
            cyc++;
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_we.delete();
    endtask

    logic [31:0] rd;
    int          cyc;
    int          guard;

    initial begin
        rst_i       = 1'b0;
        cfg_req_i   = 1'b0;
        cfg_we_i    = 1'b0;
        cfg_addr_i  = 32'h0;
        cfg_wdata_i = 32'h0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_req",   {31'b0, host_req_o}, 32'h0);
        check("rst_busy",  {31'b0, busy_o}, 32'h0);
        check("rst_done",  {31'b0, done_o}, 32'h0);
        check("rst_addr",  host_addr_o, 32'h0);
        check("rst_rdata", cfg_rdata_o, 32'h0);
        rst_i = 1'b1;
        @(negedge clk_i);

        // 1: three-word copy, immediate grant
        clear_log();
        cfg_write(32'h0, 32'h0000_0100);
        cfg_write(32'h4, 32'h0000_2000);
        cfg_write(32'h8, 32'h3);
        cfg_read(32'h0, rd);
        check("src_rb", rd, 32'h100);
        cfg_write(32'hC, 32'h1);
        check("t1_busy_start", {31'b0, busy_o}, 32'h1);
        wait_done(40, cyc);
        check("t1_done_lat", cyc, 32'd10);
        check("t1_busy_in_done", {31'b0, busy_o}, 32'h1);
        @(negedge clk_i);
        check("t1_done_pulse", {31'b0, done_o}, 32'h0);
        check("t1_busy_end", {31'b0, busy_o}, 32'h0);
        check("t1_nxact", log_addr.size(), 32'd6);
        check("t1_a0", log_addr[0], 32'h100);
        check("t1_w0", {31'b0, log_we[0]}, 32'h0);
        check("t1_a1", log_addr[1], 32'h2000);
        check("t1_w1", {31'b0, log_we[1]}, 32'h1);
        check("t1_d1", log_data[1], 32'h11);
        check("t1_a2", log_addr[2], 32'h104);
        check("t1_a3", log_addr[3], 32'h2004);
        check("t1_d3", log_data[3], 32'h22);
        check("t1_a4", log_addr[4], 32'h108);
        check("t1_a5", log_addr[5], 32'h2008);
        check("t1_d5", log_data[5], 32'h33);
        cfg_read(32'hC, rd);
        check("t1_stat", rd, 32'h1);

        // 2: same copy with every request stalled four cycles
        cfg_write(32'hC, 32'h2);
        cfg_read(32'hC, rd);
        check("t2_clr_done", rd, 32'h0);
        clear_log();
        stab_err = 0;
        stall    = 4;
        cfg_write(32'hC, 32'h1);
        cfg_read(32'hC, rd);
        check("t2_stat_busy", rd, 32'h2);
        wait_done(200, cyc);
        check("t2_done_seen", {31'b0, done_o}, 32'h1);
        @(negedge clk_i);
        check("t2_stable", stab_err, 32'd0);
        check("t2_nxact", log_addr.size(), 32'd6);
        check("t2_a2", log_addr[2], 32'h104);
        check("t2_a5", log_addr[5], 32'h2008);
        check("t2_d5", log_data[5], 32'h33);
        check("t2_d3", log_data[3], 32'h22);
        stall = 0;

        // 3: zero-length start
        clear_log();
        cfg_write(32'h8, 32'h0);
        cfg_write(32'hC, 32'h1);
        check("t3_done", {31'b0, done_o}, 32'h1);
        check("t3_busy", {31'b0, busy_o}, 32'h1);
        @(negedge clk_i);
        check("t3_done_end", {31'b0, done_o}, 32'h0);
        check("t3_busy_end", {31'b0, busy_o}, 32'h0);
        @(negedge clk_i);
        check("t3_no_xact", log_addr.size(), 32'd0);

        // 4: register write and second start while busy are ignored
        cfg_write(32'h8, 32'h3);
        clear_log();
        cfg_write(32'hC, 32'h1);
        cfg_write(32'h0, 32'hFFFF_FFF0);
        cfg_write(32'hC, 32'h1);
        cfg_read(32'hC, rd);
        check("t4_stat_busy", rd, 32'h2);
        wait_done(60, cyc);
        check("t4_done_seen", {31'b0, done_o}, 32'h1);
        repeat (6) @(negedge clk_i);
        check("t4_busy_after", {31'b0, busy_o}, 32'h0);
        check("t4_nxact", log_addr.size(), 32'd6);
        check("t4_a0", log_addr[0], 32'h100);
        check("t4_a4", log_addr[4], 32'h108);
        check("t4_d5", log_data[5], 32'h33);
        cfg_read(32'h0, rd);
        check("t4_src_kept", rd, 32'h100);

        // 5: source address wraps past the top of the address space
        clear_log();
        cfg_write(32'h0, 32'hFFFF_FFFC);
        cfg_write(32'h4, 32'h0000_3000);
        cfg_write(32'h8, 32'h2);
        cfg_write(32'hC, 32'h1);
        wait_done(40, cyc);
        check("t5_done_lat", cyc, 32'd7);
        @(negedge clk_i);
        check("t5_a0", log_addr[0], 32'hFFFF_FFFC);
        check("t5_d1", log_data[1], 32'hA5A5_FFFC);
        check("t5_a2_wrap", log_addr[2], 32'h0);
        check("t5_a3", log_addr[3], 32'h3004);
        check("t5_d3", log_data[3], 32'h5A5A_0000);
        cfg_read(32'h8, rd);
        check("t5_len_kept", rd, 32'h2);

        // 6: reset asserted during a write request
        cfg_write(32'h0, 32'h0000_0100);
        cfg_write(32'h4, 32'h0000_2000);
        cfg_write(32'h8, 32'h3);
        cfg_write(32'hC, 32'h1);
        guard = 0;
        while (!(host_req_o && host_we_o) && guard < 20) begin
            @(negedge clk_i);
            guard++;
        end
        check("t6_reach_wr", {31'b0, host_req_o & host_we_o}, 32'h1);
        #1 rst_i = 1'b0;
        #1;
        check("t6_req_async", {31'b0, host_req_o}, 32'h0);
        check("t6_we", {31'b0, host_we_o}, 32'h0);
        check("t6_busy", {31'b0, busy_o}, 32'h0);
        check("t6_addr", host_addr_o, 32'h0);
        check("t6_wdata", host_wdata_o, 32'h0);
        check("t6_rdata", cfg_rdata_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        clear_log();
        @(negedge clk_i);
        @(negedge clk_i);
        check("t6_no_traffic", log_addr.size(), 32'd0);
        cfg_read(32'hC, rd);
        check("t6_stat", rd, 32'h0);
        cfg_read(32'h8, rd);
        check("t6_len_clr", rd, 32'h0);
        cfg_write(32'h0, 32'h0000_0104);
        cfg_write(32'h4, 32'h0000_4000);
        cfg_write(32'h8, 32'h1);
        clear_log();
        cfg_write(32'hC, 32'h1);
        wait_done(40, cyc);
        check("t6_done_lat", cyc, 32'd4);
        @(negedge clk_i);
        check("t6_nxact", log_addr.size(), 32'd2);
        check("t6_a1", log_addr[1], 32'h4000);
        check("t6_d1", log_data[1], 32'h22);

        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end

endmodule
